// File: rtl/pio_poll_pkg.sv
// Shared types and constants for the PIO poll scheduler: FSM states,
// CSR word addresses, CSR field positions and the event record.
package pio_poll_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_READ    = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

  localparam logic [1:0] CSR_CONTROL = 2'd0;
  localparam logic [1:0] CSR_STATUS  = 2'd1;
  localparam logic [1:0] CSR_EVENT   = 2'd2;
  localparam logic [1:0] CSR_LEVELS  = 2'd3;

  localparam int unsigned CTRL_ENABLE_BIT = 0;
  localparam int unsigned CTRL_IRQ_EN_BIT = 1;
  localparam int unsigned EVT_VALID_BIT   = 31;
  localparam int unsigned EVT_LEVEL_BIT   = 8;
  localparam int unsigned EVT_IDX_W       = 4;
  localparam int unsigned STAT_OVF_BIT    = 31;
  localparam int unsigned STAT_COUNT_W    = 5;

  // One queued level change: new level plus the port it came from.
  typedef struct packed {
    logic                 level;
    logic [EVT_IDX_W-1:0] idx;
  } event_t;

  // CSR view of a valid event.
  function automatic logic [31:0] event_word(input event_t ev);
    logic [31:0] w;
    w                  = '0;
    w[EVT_VALID_BIT]   = 1'b1;
    w[EVT_LEVEL_BIT]   = ev.level;
    w[EVT_IDX_W-1:0]   = ev.idx;
    return w;
  endfunction

endpackage

// File: rtl/pio_poll_scheduler_fifo.sv
// Synchronous event FIFO. A pop on an empty FIFO is ignored; a push into a
// full FIFO only lands when a pop frees the head slot in the same cycle.
module pio_event_fifo
  import pio_poll_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  event_t        push_data,
  input  logic          pop,
  output event_t        pop_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int unsigned AW = $clog2(DEPTH);

  event_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  // Storage write; no reset needed since count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pio_poll_scheduler.sv
// Periodic poller for single-bit input PIO slaves. Sweeps all ports over a
// private Avalon-MM master, queues level-change events and exposes them via
// a CSR slave with a level interrupt.
// Optional build macro PIO_POLL_DEBOUNCE_EN: a change must be seen on two
// consecutive sweeps before it is accepted.
module pio_poll_scheduler
  import pio_poll_pkg::*;
#(
  parameter int unsigned N_PORTS    = 4,
  parameter int unsigned POLL_DIV   = 50000,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  output logic [N_PORTS-1:0] m_chipselect,
  output logic [1:0]         m_address,
  output logic               m_read,
  input  logic [31:0]        m_readdata,
  input  logic [1:0]         s_address,
  input  logic               s_read,
  input  logic               s_write,
  input  logic [31:0]        s_writedata,
  output logic [31:0]        s_readdata,
  output logic               irq
);

  localparam int unsigned IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [N_PORTS-1:0] CS_BASE = N_PORTS'(1);

  state_t             state;
  state_t             state_next;
  logic [IDX_W-1:0]   idx;
  logic [N_PORTS-1:0] levels;
  logic               enable;
  logic               irq_en;
  logic               primed;
  logic               pending;
  logic               overflow;
  logic [31:0]        div;
  logic               tick;
  logic               last;
  logic               sample;
  logic               changed;
  logic               accept;
  logic               push;
  logic               pop;
  logic               drop;
  event_t             push_data;
  event_t             pop_data;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic [31:0]        rdata_mux;
  logic               unused_bits;

  assign unused_bits = ^{m_readdata[31:1], s_writedata[30:2]};

  assign m_address = '0;
  assign tick      = enable && (div == 32'(POLL_DIV - 1));
  assign last      = (idx == IDX_W'(N_PORTS - 1));
  assign sample    = m_readdata[0];
  assign changed   = (sample != levels[idx]);

`ifdef PIO_POLL_DEBOUNCE_EN
  logic [N_PORTS-1:0] cand;
  assign accept = primed && changed && cand[idx];

  // Candidate bit: set by the first sweep that sees a differing level,
  // consumed when the next sweep confirms it, cleared if it reverts.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cand <= '0;
    end else if (state == ST_CAPTURE) begin
      cand[idx] <= primed && changed && !cand[idx];
    end
  end
`else
  assign accept = primed && changed;
`endif

  assign push           = (state == ST_CAPTURE) && accept;
  assign push_data.level = sample;
  assign push_data.idx   = EVT_IDX_W'(idx);
  assign pop            = s_read && (s_address == CSR_EVENT);
  assign drop           = push && fifo_full && !pop;

  pio_event_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (pop_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Tick divider, free-running only while enabled.
  always_ff @(posedge clk) begin
    if (!reset_n || !enable || tick) div <= '0;
    else                             div <= div + 32'd1;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  // Next state and bus strobes; a disable lets the current pair finish.
  always_comb begin
    state_next   = state;
    m_read       = 1'b0;
    m_chipselect = '0;
    case (state)
      ST_IDLE: begin
        if (enable && (tick || pending)) state_next = ST_READ;
      end
      ST_READ: begin
        m_read       = 1'b1;
        m_chipselect = CS_BASE << idx;
        state_next   = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (!enable || last) state_next = ST_IDLE;
        else                 state_next = ST_READ;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Sweep datapath: port index, accepted levels and baseline priming.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      idx    <= '0;
      levels <= '0;
      primed <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!enable) primed <= 1'b0;
          idx <= '0;
        end
        ST_CAPTURE: begin
          if (!primed || accept) levels[idx] <= sample;
          if (!enable)   primed <= 1'b0;
          else if (last) primed <= 1'b1;
          if (!last) idx <= idx + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  // One-deep memory of a tick that arrived while a sweep was running.
  always_ff @(posedge clk) begin
    if (!reset_n || !enable)                     pending <= 1'b0;
    else if (state == ST_IDLE)                   pending <= 1'b0;
    else if (tick)                               pending <= 1'b1;
  end

  // CSR read mux.
  always_comb begin
    rdata_mux = '0;
    case (s_address)
      CSR_CONTROL: begin
        rdata_mux[CTRL_ENABLE_BIT] = enable;
        rdata_mux[CTRL_IRQ_EN_BIT] = irq_en;
      end
      CSR_STATUS: begin
        rdata_mux[STAT_OVF_BIT]        = overflow;
        rdata_mux[STAT_COUNT_W-1:0]    = STAT_COUNT_W'(fifo_count);
      end
      CSR_EVENT: begin
        if (!fifo_empty) rdata_mux = event_word(pop_data);
      end
      default: rdata_mux = 32'(levels);
    endcase
  end

  // CSR registers, sticky overflow (set beats clear), registered irq.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      enable     <= 1'b0;
      irq_en     <= 1'b0;
      overflow   <= 1'b0;
      s_readdata <= '0;
      irq        <= 1'b0;
    end else begin
      if (s_write && (s_address == CSR_CONTROL)) begin
        enable <= s_writedata[CTRL_ENABLE_BIT];
        irq_en <= s_writedata[CTRL_IRQ_EN_BIT];
      end
      if (drop)
        overflow <= 1'b1;
      else if (s_write && (s_address == CSR_STATUS) && s_writedata[STAT_OVF_BIT])
        overflow <= 1'b0;
      if (s_read) s_readdata <= rdata_mux;
      irq <= irq_en && !fifo_empty;
    end
  end

endmodule

// File: doc/pio_poll_scheduler.md
# pio_poll_scheduler

Polling controller for the single-bit Avalon input PIO slaves that carry robot and game status lines. It sequences periodic reads of N PIO slaves over a private Avalon-MM master port, detects level changes, and queues change events in a small FIFO. A CSR slave exposes the FIFO and an interrupt to the Nios II.

## Interface
Parameters:
- N_PORTS, 4: number of PIO slaves polled (1..16).
- POLL_DIV, 50000: clk cycles between sweep starts (1 ms at 50 MHz); minimum 2*N_PORTS+2.
- FIFO_DEPTH, 8: event FIFO entries, power of two.

Ports:
- clk  in  1  system clock; one clock domain.
- reset_n  in  1  reset, synchronous, active-low.
- m_chipselect  out  N_PORTS  one-hot PIO select.
- m_address  out  2  always 0 (data register).
- m_read  out  1  read strobe; fixed read latency 1.
- m_readdata  in  32  PIO readdata; only bit 0 used.
- s_address  in  2  CSR word address.
- s_read  in  1  CSR read strobe.
- s_write  in  1  CSR write strobe.
- s_writedata  in  32  CSR write data.
- s_readdata  out  32  CSR read data, registered, latency 1.
- irq  out  1  level interrupt.

## Operation
CSR map:
- 0 CONTROL (RW): bit0 ENABLE, bit1 IRQ_EN.
- 1 STATUS (RO except bit31): [4:0] fifo count, bit31 OVERFLOW sticky, write 1 clears.
- 2 EVENT (read pops): bit31 VALID, bit8 new level, [3:0] port index. Reading when empty returns 0 and does not pop.
- 3 LEVELS (RO): [N_PORTS-1:0] last accepted level of each port.

FSM states: IDLE, READ, CAPTURE.
- IDLE: on tick (or pending tick) with ENABLE=1 -> READ, idx=0.
- READ: m_read=1, m_chipselect=1<<idx for exactly one cycle -> CAPTURE.
- CAPTURE: sample m_readdata[0]; if it differs from LEVELS[idx] and the baseline is primed, push event {idx, level} and update LEVELS[idx]. If idx=N_PORTS-1 -> IDLE and primed=1, else idx+1 -> READ.
- Sweep cost: 2*N_PORTS cycles.
- Tick divider free-runs while ENABLE=1. A tick during a sweep sets a one-deep pending flag; extra ticks are lost.
- First sweep after reset or a 0->1 ENABLE transition loads LEVELS only and pushes no events (primed=0).
- ENABLE cleared mid-sweep: the current READ/CAPTURE pair completes, then -> IDLE, primed=0.
- FIFO full on push: event dropped, OVERFLOW set. Push and pop in the same cycle when full: both succeed, count unchanged. Push and pop in the same cycle when empty: the popped read returns VALID=0; the push lands.
- irq = IRQ_EN & (count != 0), registered.

## Timing
- Reset values:
  - Outputs: m_chipselect=0, m_read=0, m_address=0, s_readdata=0, irq=0.
  - Internal: CONTROL=0, LEVELS=0, FIFO empty, OVERFLOW=0, divider=0, primed=0, pending=0.
- Reset asserted mid-sweep aborts on the next edge; no event is pushed.
- Event visible in STATUS count one cycle after CAPTURE. irq rises one cycle after that.
- EVENT read: s_readdata is valid the cycle after s_read; the pop takes effect on the same edge.
- First tick comes POLL_DIV cycles after ENABLE set.

## Configuration
- PIO_POLL_DEBOUNCE_EN defined:
  - A change is accepted only after two consecutive sweeps sample the same new level.
  - Adds one candidate bit per port.
  - A single-sweep glitch produces no event.
- Undefined: every sampled change is accepted immediately.

## Structure
- Package pio_poll_pkg:
  - FSM state enum.
  - CSR address constants.
  - Field positions (VALID=31, LEVEL=8, IDX=[3:0], OVERFLOW=31).
  - Event width typedef.
- Sub-module pio_event_fifo:
  - Synchronous FIFO with push, pop, full, empty and count.
  - Same-cycle push+pop rules as above.

## Test plan
- Baseline: N_PORTS=4, POLL_DIV=20, inputs 4'b0101, ENABLE=1 -> after the first sweep LEVELS=0x5, count=0, irq=0.
- Change: port 2 goes to 0, IRQ_EN=1 -> one event; EVENT read returns 0x8000_0002; irq drops one cycle after the pop.
- Overflow: FIFO_DEPTH=8, toggle port 0 on each of 10 sweeps, no reads -> count=8, OVERFLOW=1; write 0x8000_0000 to STATUS clears it.
- Empty pop and simultaneous push/pop: EVENT read when empty returns 0x0000_0000. Pop on the same cycle as a push into a full FIFO leaves count=8.
- Reset/disable mid-sweep: drop reset_n during READ of port 1 -> all outputs 0 next cycle, no event. Clear ENABLE mid-sweep -> m_read stays low after the current pair.
- Debounce (macro defined): port 3 high for one sweep only -> no event; high for two sweeps -> one event 0x8000_0103.
